// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic family (multipliers, dividers).
package arith_pkg;

  // Default operand width for the family
  localparam int ARITH_WIDTH = 4;

  // Control FSM encoding; the divider family uses the same encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } arith_state_e;

  // Counter width able to hold 0..w without wrapping
  function automatic int cnt_bits(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mult_datapath.sv
// Shift-add datapath: operand capture, 2*WIDTH accumulator, iteration counter
// and the held Product register. Sequencing comes from the FSM in the top.
module mult_datapath
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,     // capture operands, clear acc/counter
  input  logic               step_i,     // perform one shift-add iteration
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               last_o,     // current iteration is the final one
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = cnt_bits(WIDTH);
  localparam int PW = 2 * WIDTH;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    prod_q, prod_d;

  logic [PW-1:0]    a_ext;
  logic [WIDTH-1:0] b_sh;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    sum;

  // Partial product for this iteration: multiplier bit cnt selects a shifted
  // multiplicand. Operands are never shifted in place so they stay stable.
  always_comb begin
    a_ext  = {{WIDTH{1'b0}}, a_q};
    b_sh   = b_q >> cnt_q;
    addend = b_sh[0] ? (a_ext << cnt_q) : '0;
    sum    = acc_q + addend;
  end

  assign last_o    = (cnt_q == CW'(WIDTH - 1));
  assign product_o = prod_q;

  // Next-state: load has priority, otherwise iterate while stepping
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    prod_d = prod_q;
    if (load_i) begin
      a_d   = a_i;
      b_d   = b_i;
      acc_d = '0;
      cnt_d = '0;
    end else if (step_i) begin
      acc_d = sum;
      cnt_d = cnt_q + CW'(1);
      if (last_o) prod_d = sum;
    end
  end

  // Datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      prod_q <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      prod_q <= prod_d;
    end
  end

endmodule

// File: rtl/multiplier_4bit_seq.sv
// Sequential unsigned multiplier: IDLE/RUN/DONE control around a shift-add
// datapath. One operand pair per operation, WIDTH RUN cycles, valid/ready on
// both sides with registered handshake outputs.
module multiplier_4bit_seq
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] Product
);

  arith_state_e state_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         load;
  logic         step;
  logic         last;

  // Datapath controls are pure state decodes, gated by in_valid only in IDLE
  always_comb begin
    load = (state_q == IDLE) && in_valid;
    step = (state_q == RUN);
  end

  mult_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .step_i    (step),
    .a_i       (A),
    .b_i       (B),
    .last_o    (last),
    .product_o (Product)
  );

  // Control FSM; handshake flags are registered alongside the state so they
  // never depend combinationally on inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q    <= RUN;
            in_ready_q <= 1'b0;
          end
        end
        RUN: begin
          if (last) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // Return to IDLE only; a new accept waits for the following edge
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multiplier_4bit_seq.sv
// Directed + exhaustive bench for multiplier_4bit_seq with a product scoreboard.
module tb_multiplier_4bit_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [2*W-1:0] Product;

  int           n_vec = 0;
  int           n_miss = 0;
  logic [7:0]   sb[$];
  logic [7:0]   last_prod;

  always #5 clk = ~clk;

  multiplier_4bit_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Product   (Product)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full operation: accept, WIDTH RUN edges, optional stall, handshake.
  // jam keeps in_valid high and scrambles A/B while the operation is busy.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input int stall, input bit jam);
    int lat;
    logic [7:0] exp;
    chk("rdy_idle", 32'(in_ready), 32'd1);
    A = a; B = b; in_valid = 1'b1;
    sb.push_back(8'(a) * 8'(b));
    tick();
    if (!jam) in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 8) begin
      chk("rdy_busy", 32'(in_ready), 32'd0);
      chk("prod_hold", 32'(Product), 32'(last_prod));
      if (jam) begin A = 4'($urandom); B = 4'($urandom); end
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'd4);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      exp = '0;
    end else begin
      exp = sb.pop_front();
    end
    chk("product", 32'(Product), 32'(exp));
    out_ready = 1'b0;
    repeat (stall) begin
      tick();
      chk("stall_vld", 32'(out_valid), 32'd1);
      chk("stall_prod", 32'(Product), 32'(exp));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_vld", 32'(out_valid), 32'd0);
    chk("hs_rdy", 32'(in_ready), 32'd1);
    chk("hs_prod", 32'(Product), 32'(exp));
    in_valid = 1'b0;
    last_prod = exp;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    last_prod = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_prod", 32'(Product), 32'd0);

    // out_ready while idle is ignored
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_ordy_rdy", 32'(in_ready), 32'd1);
    chk("idle_ordy_vld", 32'(out_valid), 32'd0);

    run_op(4'd10, 4'd3, 0, 1'b0);
    run_op(4'd15, 4'd15, 0, 1'b0);
    run_op(4'd0, 4'd9, 0, 1'b0);
    run_op(4'd9, 4'd4, 3, 1'b0);

    // Abort at the 2nd RUN edge; out_ready and in_valid high must lose to rst
    A = 4'd7; B = 4'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("abort_busy", 32'(in_ready), 32'd0);
    rst = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("abort_rdy", 32'(in_ready), 32'd1);
    chk("abort_vld", 32'(out_valid), 32'd0);
    chk("abort_prod", 32'(Product), 32'd0);
    last_prod = '0;
    run_op(4'd7, 4'd5, 1, 1'b0);

    // in_valid held with changing operands during the operation
    run_op(4'd6, 4'd11, 0, 1'b1);
    run_op(4'd13, 4'd2, 2, 1'b1);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_op(4'(a), 4'(b), int'($urandom_range(0, 2)), 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/multiplier_4bit_seq.md
MULTIPLIER_4BIT_SEQ -- requirements
Module: multiplier_4bit_seq

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal values 2..16.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 in_valid  input  1  operand pair on A/B is offered.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 A  input  WIDTH  multiplicand, unsigned.
REQ-007 B  input  WIDTH  multiplier, unsigned.
REQ-008 out_valid  output  1  Product holds a completed result.
REQ-009 out_ready  input  1  consumer accepts Product.
REQ-010 Product  output  2*WIDTH  unsigned product A*B.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-012 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; both are decoded from state with no combinational path from inputs.
REQ-013 Accept: IDLE with in_valid=1 at an edge SHALL capture A and B into internal registers, clear the accumulator, clear the iteration counter, and enter RUN.
REQ-014 A, B and in_valid SHALL be ignored in RUN and DONE; captured operands stay stable there.
REQ-015 RUN SHALL do one shift-add iteration per edge, LSB of multiplier first: when the current multiplier bit is 1, add the multiplicand shifted left by the iteration index into the 2*WIDTH accumulator.
REQ-016 Accumulator arithmetic SHALL be 2*WIDTH bits wide and SHALL never overflow (max (2^WIDTH-1)^2).
REQ-017 RUN SHALL last exactly WIDTH edges regardless of operand values; no early exit on zero operands.
REQ-018 At the WIDTH-th RUN edge, the final sum SHALL be written to Product and the FSM SHALL enter DONE; out_valid is therefore first high WIDTH edges after the accepting edge.
REQ-019 DONE SHALL hold Product and out_valid stable until out_ready=1 at an edge, then return to IDLE.
REQ-020 The output handshake edge and a new accept SHALL NOT coincide: a new pair is accepted no earlier than the edge after return to IDLE.
REQ-021 Product SHALL keep the last result after leaving DONE and change only at the final RUN edge of the next operation or on reset.
REQ-022 out_ready in IDLE or RUN SHALL have no effect.
REQ-023 Iteration counter SHALL be ceil(log2(WIDTH+1)) bits and SHALL NOT wrap inside one operation.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, Product=0, accumulator=0, counter=0, captured operands=0, from any state.
REQ-025 Reset during RUN or DONE SHALL abort the operation with no out_valid pulse; the next cycle shows in_ready=1, out_valid=0.
REQ-026 rst SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-027 State encoding (IDLE=0, RUN=1, DONE=2, 2 bits) and default WIDTH SHALL live in shared package arith_pkg, also used by the divider family.
REQ-028 The shift-add datapath (operand registers, accumulator, counter) SHALL be one sub-module, mult_datapath, driven by the FSM in multiplier_4bit_seq.
REQ-029 Design SHALL be fully synchronous, no latches, no inferred "*" operator.

Verification
REQ-030 A=10, B=3 accepted at edge N -> out_valid high after edge N+4, Product=30 (8'h1E), in_ready low meanwhile.
REQ-031 A=15, B=15 -> Product=225 (8'hE1); A=0, B=9 -> Product=0 with same 4-edge latency.
REQ-032 A=9, B=4 result with out_ready held 0 for 3 cycles -> Product=36 and out_valid stay stable, IDLE entered the edge after out_ready=1.
REQ-033 rst=1 at the 2nd RUN edge of A=7, B=5 -> next cycle in_ready=1, out_valid=0, Product=0; following A=7, B=5 gives 35.
REQ-034 in_valid held high with changing A/B during RUN -> result uses only the accepted pair; back-to-back ops have ≥1 IDLE cycle between.
REQ-035 Exhaustive sweep of all 256 (A,B) pairs with random out_ready stalls -> every Product equals A*B against a scoreboard.
